// File: rtl/mod_mul_seq.sv
// Sequential modular multiplier over the secp256k1 field prime: MSB-first
// double-and-add, one bit of the multiplier per cycle, 256 cycles per product.
module mod_mul_seq #(
  parameter logic [255:0] P = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] a,
  input  logic [255:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [256:0] P_W = {1'b0, P};

  state_t       state, state_nxt;
  logic [255:0] acc, a_r, b_r;
  logic [7:0]   cnt;

  logic [256:0] dbl, sum;
  logic [255:0] dbl_red, sum_red, acc_nxt;

  // Any 256-bit value is below 2P, so a single conditional subtract reduces it.
  function automatic logic [255:0] reduce(input logic [255:0] x);
    return (x >= P) ? x - P : x;
  endfunction

  // One step of the double-and-add; every temporary stays within 257 bits
  // and each partial result is brought back into [0, P-1] before reuse.
  always_comb begin
    dbl     = {acc, 1'b0};
    dbl_red = (dbl >= P_W) ? 256'(dbl - P_W) : dbl[255:0];
    sum     = {1'b0, dbl_red} + {1'b0, a_r};
    sum_red = (sum >= P_W) ? 256'(sum - P_W) : sum[255:0];
    acc_nxt = b_r[cnt] ? sum_red : dbl_red;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave state_nxt unassigned and infer a latch.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = in_valid ? BUSY : IDLE;
      BUSY:    state_nxt = (cnt == 8'd0) ? DONE : BUSY;
      DONE:    state_nxt = out_ready ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      a_r <= '0;
      b_r <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r <= reduce(a);
            b_r <= reduce(b);
            acc <= '0;
            cnt <= 8'd255;
          end
        end
        BUSY: begin
          acc <= acc_nxt;
          cnt <= cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign product   = acc;

endmodule

// File: tb/tb_mod_mul_seq.sv
// Self-checking bench for mod_mul_seq: a reference model of (a*b) mod P and
// the handshake timing, compared against the DUT on every falling edge.
module tb_mod_mul_seq;

  localparam logic [255:0] P = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
  localparam int LAT = 256;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [255:0] a = '0;
  logic [255:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [255:0] product;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ops    = 0;
  int n_results = 0;

  mod_mul_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] mm(input logic [255:0] x, input logic [255:0] y);
    logic [511:0] w;
    w = ({256'b0, x} * {256'b0, y}) % {256'b0, P};
    return w[255:0];
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [255:0] pick_operand();
    case ($urandom_range(0, 3))
      0:       return rnd256();
      1:       return P + 256'($urandom_range(0, 1000));
      2:       return P - 256'($urandom_range(1, 1000));
      default: return 256'($urandom);
    endcase
  endfunction

  // Reference model: one operation in flight, result due LAT edges after accept.
  int           cyc = 0;
  int           acc_cyc = 0;
  logic         pending = 1'b0;
  logic [255:0] exp_prod = '0;
  logic [255:0] last_prod = '0;

  function automatic logic model_valid();
    return pending && (cyc - acc_cyc >= LAT);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else if (!pending && in_valid) begin
      pending  <= 1'b1;
      acc_cyc  <= cyc + 1;
      exp_prod <= mm(a, b);
    end else if (model_valid() && out_ready) begin
      pending   <= 1'b0;
      last_prod <= product;
      n_results <= n_results + 1;
    end
  end

  // Compare process: handshake outputs every cycle, product whenever valid.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", 256'(in_ready), 256'(!pending));
      check("out_valid", 256'(out_valid), 256'(model_valid()));
      if (model_valid()) begin
        check("product", product, exp_prod);
        check("in_ready_while_done", 256'(in_ready), 256'(0));
      end
    end
  end

  // Call just after a falling edge; offers one operand pair for one cycle.
  task automatic issue(input logic [255:0] ta, input logic [255:0] tb);
    in_valid = 1'b1;
    a = ta;
    b = tb;
    @(negedge clk); #1;
    in_valid = 1'b0;
    a = rnd256();
    b = rnd256();
    n_ops++;
  endtask

  // Waits for the result with a bounded loop, then takes it after gap stall cycles.
  task automatic collect(input int gap);
    int t = 0;
    while (!model_valid()) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      @(negedge clk); #1;
      t++;
      if (t > LAT + 20) begin
        n_checks++;
        n_fail++;
        $display("FAIL result_timeout: waited %0d cycles, required at most %0d", t, LAT);
        break;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (gap) begin
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic directed(input string name, input logic [255:0] ta, input logic [255:0] tb,
                          input logic [255:0] exp, input int gap);
    check({name, "_model"}, mm(ta, tb), exp);
    issue(ta, tb);
    collect(gap);
    check(name, last_prod, exp);
  endtask

  initial begin
    #1;
    check("reset_in_ready", 256'(in_ready), 256'(1));
    check("reset_out_valid", 256'(out_valid), 256'(0));
    check("reset_product", product, '0);

    // First accept on the first rising edge after reset release.
    @(negedge clk); #1;
    rst_n = 1'b1;
    directed("one_times_one", 256'd1, 256'd1, 256'd1, 0);
    directed("pm1_squared", P - 256'd1, P - 256'd1, 256'd1, 1);
    directed("two_pow_256", 256'd1 << 255, 256'd2, 256'h1000003D1, 0);
    directed("p_times_5", P, 256'd5, 256'd0, 2);
    directed("unreduced_pair", P + 256'd3, P + 256'd4, 256'd12, 0);
    directed("backpressure", 256'h1234_5678_9abc_def0, P - 256'd7, mm(256'h1234_5678_9abc_def0, P - 256'd7), 10);

    // Reset in the middle of a multiplication aborts it without a result.
    issue(rnd256(), rnd256());
    repeat (100) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 256'(out_valid), 256'(0));
    check("abort_in_ready", 256'(in_ready), 256'(1));
    check("abort_product", product, '0);
    n_ops--;
    @(negedge clk); #1;
    rst_n = 1'b1;
    directed("after_abort", 256'd3, 256'd7, 256'd21, 0);

    for (int i = 0; i < 200; i++) begin
      issue(pick_operand(), pick_operand());
      collect($urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    check("result_count", 256'(n_results), 256'(n_ops));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
